// File: rtl/demux_rr_n_pkg.sv
// Shared defaults and helpers for the demux_rr_n stream demultiplexer.
// Optional explicit channel steering is compiled in with DEMUX_SEL_EXT_EN.
package demux_rr_n_pkg;

  localparam int BW_DEF     = 8;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W      = 16;

  // Channel index width; a single channel still needs one bit to exist.
  function automatic int sel_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/demux_rr_n_if.sv
// Stream bundle for demux_rr_n: one input beat stream and NUM_CH output streams.
// slave is the demux side, master is the upstream/downstream environment side.
interface demux_rr_n_if import demux_rr_n_pkg::*; #(
  parameter int BW     = BW_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) ();

  logic [BW-1:0]        Entrada;
  logic                 validEntrada;
  logic                 readyEntrada;
  logic [NUM_CH*BW-1:0] Salida;
  logic [NUM_CH-1:0]    validSalida;
  logic [NUM_CH-1:0]    readySalida;

  modport slave (
    input  Entrada,
    input  validEntrada,
    output readyEntrada,
    output Salida,
    output validSalida,
    input  readySalida
  );

  modport master (
    output Entrada,
    output validEntrada,
    input  readyEntrada,
    input  Salida,
    input  validSalida,
    output readySalida
  );

endinterface

// File: rtl/demux_rr_n_etapa.sv
// Single-channel registered output stage with valid/ready handshake.
// A load and a drain in the same cycle keep valid high so the stream has no bubble.
module demux_rr_etapa #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [BW-1:0] beat,
  input  logic          ready,
  output logic [BW-1:0] data,
  output logic          valid,
  output logic          can_load
);

  assign can_load = !valid || ready;

  // Data only changes on a load; a plain drain leaves the last beat visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= beat;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  a_load_when_free: assert property (@(posedge clk) disable iff (!reset) load |-> can_load);

endmodule

// File: rtl/demux_rr_n.sv
// Round-robin 1:NUM_CH stream demultiplexer with per-channel registered outputs.
// DEMUX_SEL_EXT_EN adds a selector port that steers beats instead of the pointer.
module demux_rr_n import demux_rr_n_pkg::*; #(
  parameter  int BW     = BW_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int SELW   = sel_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  demux_rr_n_if.slave      bus,
  output logic [SELW-1:0]  canal,
  output logic [CNT_W-1:0] cuenta
`ifdef DEMUX_SEL_EXT_EN
  ,
  input  logic [SELW-1:0]  selector
`endif
);

  logic [SELW-1:0]      target;
  logic [NUM_CH-1:0]    can_load;
  logic [NUM_CH-1:0]    load;
  logic [NUM_CH*BW-1:0] salida_q;
  logic [NUM_CH-1:0]    valid_q;
  logic                 accept;

`ifdef DEMUX_SEL_EXT_EN
  assign target = selector;
`else
  assign target = canal;
`endif

  assign bus.readyEntrada = can_load[target];
  assign accept           = bus.validEntrada && bus.readyEntrada;

  always_comb begin
    load         = '0;
    load[target] = accept;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_etapa
    demux_rr_etapa #(
      .BW(BW)
    ) u_etapa (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .beat     (bus.Entrada),
      .ready    (bus.readySalida[i]),
      .data     (salida_q[i*BW +: BW]),
      .valid    (valid_q[i]),
      .can_load (can_load[i])
    );
  end

  assign bus.Salida      = salida_q;
  assign bus.validSalida = valid_q;

  // The pointer advances on every accept even when the selector steers,
  // so canal always reports the round-robin position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      canal  <= '0;
      cuenta <= '0;
    end else if (accept) begin
      canal  <= (canal == SELW'(NUM_CH - 1)) ? '0 : canal + 1'b1;
      cuenta <= cuenta + 1'b1;
    end
  end

  a_single_load: assert property (@(posedge clk) disable iff (!reset) $onehot0(load));

endmodule
